// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter/sequencer sharing one pipelined 12-bit ALU among NUM_REQ requesters.
// Optional ALU_SHARE_PERF_EN adds saturating perf_issue / perf_conflict counters.
module alu_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*12-1:0] req_a,
    input  logic [NUM_REQ*12-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_sel,
    input  logic                  hold,
    output logic [11:0]           alu_a,
    output logic [11:0]           alu_b,
    output logic [2:0]            alu_sel,
    input  logic [11:0]           alu_f,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [11:0]           rsp_data
`ifdef ALU_SHARE_PERF_EN
    ,
    output logic [15:0]           perf_issue,
    output logic [15:0]           perf_conflict
`endif
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] nptr;
    logic            found;
    logic            accept;
    logic [11:0]     win_a;
    logic [11:0]     win_b;
    logic [2:0]      win_sel;

    // SEL waits here one cycle so it reaches the ALU a cycle after its operands
    logic [2:0]      sel0;
    logic [ALU_LAT:0] tag_v;
    logic [ID_W-1:0] tag_id [ALU_LAT+1];

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        accept    = found && !hold && RST;
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
        nptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    always_comb begin
        win_a   = '0;
        win_b   = '0;
        win_sel = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == winner) begin
                win_a   = req_a[12*k +: 12];
                win_b   = req_b[12*k +: 12];
                win_sel = req_sel[3*k +: 3];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ptr       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            sel0      <= '0;
            tag_v     <= '0;
            for (int unsigned k = 0; k <= ALU_LAT; k++) begin
                tag_id[k] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            alu_sel <= sel0;
            if (accept) begin
                ptr       <= nptr;
                alu_a     <= win_a;
                alu_b     <= win_b;
                sel0      <= win_sel;
                tag_v[0]  <= 1'b1;
                tag_id[0] <= winner;
            end else begin
                alu_a     <= '0;
                alu_b     <= '0;
                tag_v[0]  <= 1'b0;
            end
            for (int unsigned k = 1; k <= ALU_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            rsp_valid <= tag_v[ALU_LAT];
            rsp_id    <= tag_id[ALU_LAT];
            rsp_data  <= alu_f;
        end
    end

`ifdef ALU_SHARE_PERF_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            perf_issue    <= '0;
            perf_conflict <= '0;
        end else begin
            if (accept && perf_issue != '1) begin
                perf_issue <= perf_issue + 16'd1;
            end
            if (!hold && ($countones(req_valid) > 1) && perf_conflict != '1) begin
                perf_conflict <= perf_conflict + 16'd1;
            end
        end
    end
`else
    // no performance counters in this build
`endif

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 12-bit ALU between NUM_REQ requesters.
- Accepts ops (A, B, SEL) over per-requester valid/ready handshakes and drives the ALU operand and select inputs with the ALU's required skew (SEL one cycle after A/B).
- Tracks each op's requester ID through the ALU latency and returns the result tagged with that ID.
- Sits between client blocks and the ALU instance; the ALU shares CLK/RST.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ).
- ALU_LAT, 3, clock edges from alu_a/alu_b valid at ALU input to result on alu_f; fixed by the ALU.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester op valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*12  packed operand A; requester i at bits [12i+11:12i].
- req_b  in  NUM_REQ*12  packed operand B, same packing.
- req_sel  in  NUM_REQ*3  packed ALU op code; requester i at bits [3i+2:3i].
- hold  in  1  when high, no new grants; in-flight ops drain.
- alu_a  out  12  to ALU A, registered.
- alu_b  out  12  to ALU B, registered.
- alu_sel  out  3  to ALU SEL, registered; lags alu_a/alu_b by one cycle.
- alu_f  in  12  from ALU F.
- rsp_valid  out  1  result valid, one-cycle pulse per op.
- rsp_id  out  ID_W  requester index of the result.
- rsp_data  out  12  ALU result.

Behaviour:
- Reset (RST=0 at a posedge): alu_a, alu_b, alu_sel, rsp_data = 0; rsp_valid = 0; rsp_id = 0; RR pointer = 0; all tag-pipeline valids cleared.
- Reset mid-operation: in-flight ops are dropped and no response is produced for them.
- Arbitration is combinational:
  - Winner = first i with req_valid[i]=1, scanning from ptr, ptr+1, ... mod NUM_REQ.
  - req_ready[winner]=1 only when hold=0 and RST=1; all other bits are 0.
  - Requesters must not make valid depend on ready.
  - req_valid may drop without a handshake.
- Accept: handshake at edge E0 when req_valid[i] & req_ready[i].
  - ptr <= (i+1) mod NUM_REQ; ptr is unchanged when nothing is granted.
  - Sustained rate: one accept per cycle.
- Issue timing:
  - E0: alu_a/alu_b <= req_a[i]/req_b[i]; SEL and ID are captured into stage 0.
  - E1: alu_sel <= stage-0 SEL, so the ALU captures operands at E1 and SEL at E2.
  - E3: result is on alu_f.
  - E4: rsp_data <= alu_f; rsp_valid <= 1; rsp_id <= i.
  - Handshake-to-rsp_valid latency: 4 edges (ALU_LAT+1).
- Idle cycles: alu_a/alu_b <= 0; alu_sel <= stage-0 SEL as-is. The tag valid is 0, so no response is produced.
- Tag pipeline: shift register of {valid, ID} with depth ALU_LAT+1, advancing every cycle; there are no stalls.
- Responses return in issue order. There is no backpressure on the response side; consumers must accept every cycle.
- Arithmetic is performed entirely by the ALU and truncated to 12 bits (e.g. MUL keeps the low 12 bits). The controller does not inspect data.
- hold asserted mid-stream: no new grants from that cycle; up to 4 outstanding responses still emerge.
- Simultaneous hold and req_valid: hold wins and ptr is unchanged.

Optional Feature:
- Macro ALU_SHARE_PERF_EN.
- Defined: adds outputs perf_issue [15:0] and perf_conflict [15:0], both reset to 0 and saturating at 0xFFFF.
  - perf_issue increments on every accept.
  - perf_conflict increments each cycle with hold=0 and two or more req_valid bits set.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Basic ADD: req0 valid, A=0x005, B=0x003, SEL=000, handshake at edge 10 -> rsp_valid pulse after edge 14, rsp_id=0, rsp_data=0x008.
- Back-to-back round-robin: all 4 requesters held valid with SEL=101 and A=0x100+i, starting ptr=0 -> grants 0,1,2,3,0,1 on consecutive cycles; responses back-to-back with ids 0,1,2,3 and data 0x101,0x102,0x103,0x104.
- Wrap/truncation:
  - SUB A=0x003, B=0x005 -> 0xFFE.
  - MUL A=0x040, B=0x040 -> 0x000.
  - INC A=0xFFF -> 0x000.
  - SHL A=0x801 -> 0x002.
- Fairness: req1 and req3 valid continuously, ptr=2 -> grant order 3,1,3,1; req_ready is never multi-hot.
- Hold: 3 ops issued, then hold=1 for 10 cycles with all req_valid high -> exactly 3 responses, no req_ready during hold; the grant after release goes to the next index after the last granted.
- Reset mid-flight: 2 ops accepted, RST=0 for one cycle 2 edges later -> no rsp_valid for those ops; alu_a=0, alu_sel=0, ptr=0; the next op completes normally.
